phys_reg_free_list_ctrl: RTL and testbench
==========================================

// Module: phys_reg_free_list_ctrl
// PURPOSE
// - Sequencer in front of phys_reg_free_list. Arbitrates dispatch rename (dequeue), checkpoint save,
//   branch restore/invalidate, ROB rollback revert and commit free (enqueue) into the free list's
//   one-exclusive-op-per-cycle control interface. Sits between dispatch, ROB and branch resolution.
// - Splits a dispatch needing both checkpoint and dest into save then dequeue; stalls dispatch on
//   empty, checkpoint-table full, revert walk and post-restore settle.
// PARAMETERS
// - NUM_CKPT  default CHECKPOINT_COLUMNS (4)  live checkpoint limit; must equal free list columns
// PORTS
// - CLK                      in   1    clock
// - nRST                     in   1    reset, asynchronous, active-low
// - ctrl_error               out  1    registered protocol violation flag
// - dispatch_valid           in   1    dispatch request; held stable until dispatch_ready
// - dispatch_needs_dest      in   1    instr writes a register -> needs phys reg
// - dispatch_needs_ckpt      in   1    instr is a branch -> needs checkpoint
// - dispatch_ROB_index       in   ROB_index_t          ROB index of dispatching instr
// - dispatch_ready           out  1    request completes this cycle
// - dispatch_dest_tag        out  phys_reg_tag_t       allocated phys reg (valid with ready & needs_dest)
// - dispatch_ckpt_column     out  checkpoint_column_t  saved column (valid with ready & needs_ckpt)
// - commit_free_valid/_tag   in   1 / phys_reg_tag_t   ROB commit frees old mapping
// - revert_req_valid/_tag    in   1 / phys_reg_tag_t   ROB rollback walk, one youngest mapping per cycle
// - revert_req_ready         out  1    revert accepted this cycle
// - restore_req_valid        in   1    branch resolved; held until restore_req_ready
// - restore_req_failed       in   1    1 = mispredict (roll back), 0 = invalidate only
// - restore_req_ROB_index    in   ROB_index_t ; restore_req_column in checkpoint_column_t
// - restore_req_ready        out  1    restore issued to free list this cycle
// - restore_done/_success    out  1 / 1  registered, pulse cycle after issue; success from free list
// - fl_dequeue_valid, fl_enqueue_valid/_tag, fl_revert_valid/_tag, fl_save_valid/_ROB_index,
//   fl_restore_valid/_failed/_ROB_index/_column   out  free list controls (matching types)
// - fl_dequeue_tag, fl_empty, fl_full, fl_save_column, fl_restore_success   in  free list status
// BEHAVIOUR
// - FSM states: IDLE, DEQ_PEND, REVERT, SETTLE. Reset: IDLE, ckpt_count=0, ctrl_error=0,
//   restore_done=0; all fl_* strobes, ready outputs 0 while nRST low.
// - Enqueue: commit_free passes through combinationally every cycle in every state; commit while
//   fl_full -> ctrl_error next cycle (enqueue still forwarded).
// - Exclusive-op priority per cycle: revert > failed restore > save > dequeue. Invalidate-only
//   restore (failed=0) may issue alongside save/dequeue, but not during REVERT.
// - REVERT: entered from any state when revert_req_valid; fl_revert_valid=revert_req_ready=1 each
//   cycle valid is high; dispatch and restore blocked; exit to IDLE when valid drops (DEQ_PEND aborted).
// - IDLE dispatch: dest only -> dequeue, ready same cycle if ~fl_empty. ckpt only -> save, ready same
//   cycle if ckpt_count<NUM_CKPT; column = fl_save_column. both -> save, latch column, ready=0, go
//   DEQ_PEND. neither -> ready same cycle, no free list op.
// - DEQ_PEND: dequeue when ~fl_empty, ready=1, column = latched; -> IDLE. Empty -> hold.
//   Failed restore here wins; pending dispatch dropped, -> SETTLE.
// - Failed restore: exclusive; -> SETTLE (dispatch blocked 1 cycle for free-list flag settle) -> IDLE.
// - ckpt_count: +1 on save; -1 on successful invalidate; =0 on successful failed restore; saturates
//   0..NUM_CKPT; underflow/overflow attempt -> ctrl_error. Failed restore with success=0 -> ctrl_error.
// - Latency: single-op dispatch 0 cycles; ckpt+dest 1 extra cycle; restore_done 1 cycle after issue.
// STRUCTURE
// - core_types_pkg: phys_reg_tag_t, ROB_index_t, checkpoint_column_t, CHECKPOINT_COLUMNS; add
//   fl_ctrl_state_t enum {IDLE,DEQ_PEND,REVERT,SETTLE}.
// - Single flat module, no sub-module; checkpoint counter inline. Bench pairs with phys_reg_free_list.
// TESTING
// - Reset, dispatch dest-only x3 -> tags NUM_ARCH_REGS+0,+1,+2 on consecutive cycles, ready each cycle.
// - Dispatch ckpt+dest at ROB 5 -> cycle0 fl_save, ready=0; cycle1 fl_dequeue, ready=1, column 0.
// - 4 ckpt-only saves then 5th -> ready held 0 until invalidate restore of column 0 succeeds.
// - Revert 3 cycles with dispatch+restore pending -> fl_revert x3, no dequeue/restore; then restore.
// - Failed restore during DEQ_PEND -> pending dequeue dropped, SETTLE 1 cycle, ckpt_count=0, done=1.
// - Drain to fl_empty -> dispatch stalls; commit_free tag 40 -> next dispatch gets 40; enqueue on full -> ctrl_error.

Source files
------------

// File: rtl/core_types_pkg.sv
// Shared rename-stage types: physical register tags, ROB indices, checkpoint columns
// and the free-list sequencer state encoding.
package core_types_pkg;

  localparam int NUM_ARCH_REGS      = 32;
  localparam int NUM_PHYS_REGS      = 64;
  localparam int ROB_DEPTH          = 32;
  localparam int CHECKPOINT_COLUMNS = 4;

  typedef logic [$clog2(NUM_PHYS_REGS)-1:0]      phys_reg_tag_t;
  typedef logic [$clog2(ROB_DEPTH)-1:0]          ROB_index_t;
  typedef logic [$clog2(CHECKPOINT_COLUMNS)-1:0] checkpoint_column_t;

  typedef enum logic [1:0] {
    IDLE,
    DEQ_PEND,
    REVERT,
    SETTLE
  } fl_ctrl_state_t;

endpackage

// File: rtl/phys_reg_free_list_ctrl.sv
// Sequencer in front of the physical register free list: serialises rename, checkpoint,
// restore and rollback traffic onto the free list's one-exclusive-op-per-cycle interface.
//
// state    | meaning
// IDLE     | accept dispatch (dequeue / save / none), restores, commits
// DEQ_PEND | checkpoint saved for a branch that also needs a dest; dequeue next
// REVERT   | ROB rollback walk in progress; dispatch and restore blocked
// SETTLE   | one-cycle dispatch bubble after a failed restore
module phys_reg_free_list_ctrl
  import core_types_pkg::*;
#(
  parameter int NUM_CKPT = CHECKPOINT_COLUMNS
) (
  input  logic               CLK,
  input  logic               nRST,
  output logic               ctrl_error,
  input  logic               dispatch_valid,
  input  logic               dispatch_needs_dest,
  input  logic               dispatch_needs_ckpt,
  input  ROB_index_t         dispatch_ROB_index,
  output logic               dispatch_ready,
  output phys_reg_tag_t      dispatch_dest_tag,
  output checkpoint_column_t dispatch_ckpt_column,
  input  logic               commit_free_valid,
  input  phys_reg_tag_t      commit_free_tag,
  input  logic               revert_req_valid,
  input  phys_reg_tag_t      revert_req_tag,
  output logic               revert_req_ready,
  input  logic               restore_req_valid,
  input  logic               restore_req_failed,
  input  ROB_index_t         restore_req_ROB_index,
  input  checkpoint_column_t restore_req_column,
  output logic               restore_req_ready,
  output logic               restore_done,
  output logic               restore_done_success,
  output logic               fl_dequeue_valid,
  output logic               fl_enqueue_valid,
  output phys_reg_tag_t      fl_enqueue_tag,
  output logic               fl_revert_valid,
  output phys_reg_tag_t      fl_revert_tag,
  output logic               fl_save_valid,
  output ROB_index_t         fl_save_ROB_index,
  output logic               fl_restore_valid,
  output logic               fl_restore_failed,
  output ROB_index_t         fl_restore_ROB_index,
  output checkpoint_column_t fl_restore_column,
  input  phys_reg_tag_t      fl_dequeue_tag,
  input  logic               fl_empty,
  input  logic               fl_full,
  input  checkpoint_column_t fl_save_column,
  input  logic               fl_restore_success
);

  localparam int CW = $clog2(NUM_CKPT + 1);
  typedef logic [CW-1:0] ckpt_count_t;
  localparam ckpt_count_t CKPT_MAX = ckpt_count_t'(NUM_CKPT);

  fl_ctrl_state_t     state, next_state;
  ckpt_count_t        ckpt_count, ckpt_count_n;
  checkpoint_column_t saved_col;
  logic               save_col_load;
  logic               fail_issue;
  logic               inv_issue;
  logic               ckpt_dec;
  logic               ctrl_error_n;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state                <= IDLE;
      ckpt_count           <= '0;
      ctrl_error           <= 1'b0;
      saved_col            <= '0;
      restore_done         <= 1'b0;
      restore_done_success <= 1'b0;
    end else begin
      state                <= next_state;
      ckpt_count           <= ckpt_count_n;
      ctrl_error           <= ctrl_error_n;
      restore_done         <= fl_restore_valid;
      restore_done_success <= fl_restore_valid & fl_restore_success;
      if (save_col_load) saved_col <= fl_save_column;
    end
  end

  always_comb begin
    next_state           = state;
    save_col_load        = 1'b0;
    fail_issue           = 1'b0;
    inv_issue            = 1'b0;
    dispatch_ready       = 1'b0;
    revert_req_ready     = 1'b0;
    restore_req_ready    = 1'b0;
    fl_dequeue_valid     = 1'b0;
    fl_enqueue_valid     = 1'b0;
    fl_revert_valid      = 1'b0;
    fl_save_valid        = 1'b0;
    fl_restore_valid     = 1'b0;
    fl_enqueue_tag       = commit_free_tag;
    fl_revert_tag        = revert_req_tag;
    fl_save_ROB_index    = dispatch_ROB_index;
    fl_restore_failed    = restore_req_failed;
    fl_restore_ROB_index = restore_req_ROB_index;
    fl_restore_column    = restore_req_column;
    dispatch_dest_tag    = fl_dequeue_tag;
    dispatch_ckpt_column = (state == DEQ_PEND) ? saved_col : fl_save_column;

    if (nRST) begin
      fl_enqueue_valid = commit_free_valid;
      if (revert_req_valid) begin
        fl_revert_valid  = 1'b1;
        revert_req_ready = 1'b1;
        next_state       = REVERT;
      end else if (state == REVERT) begin
        next_state = IDLE;
      end else if (restore_req_valid && restore_req_failed) begin
        fl_restore_valid  = 1'b1;
        restore_req_ready = 1'b1;
        fail_issue        = 1'b1;
        next_state        = SETTLE;
      end else begin
        // an invalidate-only restore never touches the free-list contents, so it rides along
        if (restore_req_valid) begin
          fl_restore_valid  = 1'b1;
          restore_req_ready = 1'b1;
          inv_issue         = 1'b1;
        end
        if (state == SETTLE) begin
          next_state = IDLE;
        end else if (dispatch_valid) begin
          if (state == DEQ_PEND) begin
            if (!fl_empty) begin
              fl_dequeue_valid = 1'b1;
              dispatch_ready   = 1'b1;
              next_state       = IDLE;
            end
          end else if (dispatch_needs_ckpt) begin
            if (ckpt_count < CKPT_MAX) begin
              fl_save_valid = 1'b1;
              if (dispatch_needs_dest) begin
                save_col_load = 1'b1;
                next_state    = DEQ_PEND;
              end else begin
                dispatch_ready = 1'b1;
              end
            end
          end else if (dispatch_needs_dest) begin
            if (!fl_empty) begin
              fl_dequeue_valid = 1'b1;
              dispatch_ready   = 1'b1;
            end
          end else begin
            dispatch_ready = 1'b1;
          end
        end
      end
    end
  end

  assign ckpt_dec = inv_issue & fl_restore_success;

  always_comb begin
    ckpt_count_n = ckpt_count;
    ctrl_error_n = ctrl_error;
    if (fl_enqueue_valid && fl_full) ctrl_error_n = 1'b1;
    if (fail_issue) begin
      if (fl_restore_success) ckpt_count_n = '0;
      else                    ctrl_error_n = 1'b1;
    end else if (fl_save_valid && !ckpt_dec) begin
      if (ckpt_count == CKPT_MAX) ctrl_error_n = 1'b1;
      else                        ckpt_count_n = ckpt_count + 1'b1;
    end else if (ckpt_dec && !fl_save_valid) begin
      if (ckpt_count == '0) ctrl_error_n = 1'b1;
      else                  ckpt_count_n = ckpt_count - 1'b1;
    end
  end

endmodule

// File: tb/tb_phys_reg_free_list_ctrl.sv
// Bench for phys_reg_free_list_ctrl: a queue-based free-list stand-in drives the status
// inputs, a transaction-level model predicts every output each cycle, and directed steps pin values.
module tb_phys_reg_free_list_ctrl;
  import core_types_pkg::*;

  logic               CLK = 1'b0;
  logic               nRST = 1'b0;
  logic               ctrl_error;
  logic               dispatch_valid = 1'b0, dispatch_needs_dest = 1'b0, dispatch_needs_ckpt = 1'b0;
  ROB_index_t         dispatch_ROB_index = '0;
  logic               dispatch_ready;
  phys_reg_tag_t      dispatch_dest_tag;
  checkpoint_column_t dispatch_ckpt_column;
  logic               commit_free_valid = 1'b0;
  phys_reg_tag_t      commit_free_tag = '0;
  logic               revert_req_valid = 1'b0;
  phys_reg_tag_t      revert_req_tag = '0;
  logic               revert_req_ready;
  logic               restore_req_valid = 1'b0, restore_req_failed = 1'b0;
  ROB_index_t         restore_req_ROB_index = '0;
  checkpoint_column_t restore_req_column = '0;
  logic               restore_req_ready, restore_done, restore_done_success;
  logic               fl_dequeue_valid, fl_enqueue_valid, fl_revert_valid, fl_save_valid;
  logic               fl_restore_valid, fl_restore_failed;
  phys_reg_tag_t      fl_enqueue_tag, fl_revert_tag;
  ROB_index_t         fl_save_ROB_index, fl_restore_ROB_index;
  checkpoint_column_t fl_restore_column;
  phys_reg_tag_t      fl_dequeue_tag = '0;
  logic               fl_empty = 1'b0, fl_full = 1'b0;
  checkpoint_column_t fl_save_column;
  logic               fl_restore_success;

  int total = 0;
  int bad = 0;

  always #5 CLK = ~CLK;

  phys_reg_free_list_ctrl dut (
    .CLK(CLK), .nRST(nRST), .ctrl_error(ctrl_error),
    .dispatch_valid(dispatch_valid), .dispatch_needs_dest(dispatch_needs_dest),
    .dispatch_needs_ckpt(dispatch_needs_ckpt), .dispatch_ROB_index(dispatch_ROB_index),
    .dispatch_ready(dispatch_ready), .dispatch_dest_tag(dispatch_dest_tag),
    .dispatch_ckpt_column(dispatch_ckpt_column),
    .commit_free_valid(commit_free_valid), .commit_free_tag(commit_free_tag),
    .revert_req_valid(revert_req_valid), .revert_req_tag(revert_req_tag),
    .revert_req_ready(revert_req_ready),
    .restore_req_valid(restore_req_valid), .restore_req_failed(restore_req_failed),
    .restore_req_ROB_index(restore_req_ROB_index), .restore_req_column(restore_req_column),
    .restore_req_ready(restore_req_ready), .restore_done(restore_done),
    .restore_done_success(restore_done_success),
    .fl_dequeue_valid(fl_dequeue_valid), .fl_enqueue_valid(fl_enqueue_valid),
    .fl_enqueue_tag(fl_enqueue_tag), .fl_revert_valid(fl_revert_valid),
    .fl_revert_tag(fl_revert_tag), .fl_save_valid(fl_save_valid),
    .fl_save_ROB_index(fl_save_ROB_index), .fl_restore_valid(fl_restore_valid),
    .fl_restore_failed(fl_restore_failed), .fl_restore_ROB_index(fl_restore_ROB_index),
    .fl_restore_column(fl_restore_column),
    .fl_dequeue_tag(fl_dequeue_tag), .fl_empty(fl_empty), .fl_full(fl_full),
    .fl_save_column(fl_save_column), .fl_restore_success(fl_restore_success)
  );

  task automatic chk(input string name, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---- free-list stand-in: FIFO of free tags plus a used-column mask ----
  int         fq[$];
  logic [3:0] col_used = '0;
  bit         s_rst = 1'b1, s_deq, s_enq, s_rev, s_save, s_rs, s_rs_f, s_rs_ok;
  int         s_enq_tag, s_rev_tag, s_save_col, s_rs_col;

  always_comb begin
    fl_save_column = '0;
    for (int i = CHECKPOINT_COLUMNS - 1; i >= 0; i--)
      if (!col_used[i]) fl_save_column = checkpoint_column_t'(i);
  end
  assign fl_restore_success = col_used[fl_restore_column];

  always @(posedge CLK) begin
    logic [3:0] cu;
    cu = col_used;
    if (s_rst) begin
      fq.delete();
      for (int i = NUM_ARCH_REGS; i < NUM_PHYS_REGS; i++) fq.push_back(i);
      cu = '0;
    end else begin
      if (s_deq && fq.size() > 0) void'(fq.pop_front());
      if (s_rev) fq.push_front(s_rev_tag);
      if (s_enq) fq.push_back(s_enq_tag);
      if (s_save) cu[s_save_col] = 1'b1;
      if (s_rs && s_rs_ok) begin
        if (s_rs_f) cu = '0;
        else        cu[s_rs_col] = 1'b0;
      end
    end
    col_used       <= cu;
    fl_empty       <= (fq.size() == 0);
    fl_full        <= (fq.size() >= NUM_PHYS_REGS - NUM_ARCH_REGS);
    fl_dequeue_tag <= phys_reg_tag_t'(fq.size() > 0 ? fq[0] : 0);
  end

  // ---- transaction-level model and per-cycle compare ----
  int                 m_cnt = 0;
  bit                 m_pend = 0, m_rev_last = 0, m_settle = 0, m_err = 0, m_done = 0, m_dsucc = 0;
  checkpoint_column_t m_col = '0;

  always @(negedge CLK) begin : compare
    bit e_rdy, e_deq, e_save, e_rs, e_rev, e_enq, fail_i, inv_i;
    int d;
    e_rdy = 0; e_deq = 0; e_save = 0; e_rs = 0; e_rev = 0; e_enq = 0; fail_i = 0; inv_i = 0;
    if (nRST) begin
      e_enq = commit_free_valid;
      if (revert_req_valid) e_rev = 1;
      else if (!m_rev_last) begin
        if (restore_req_valid) begin
          e_rs   = 1;
          fail_i = restore_req_failed;
          inv_i  = !restore_req_failed;
        end
        if (!fail_i && !m_settle && dispatch_valid) begin
          if (m_pend) begin
            e_deq = !fl_empty;
            e_rdy = e_deq;
          end else if (dispatch_needs_ckpt) begin
            e_save = (m_cnt < CHECKPOINT_COLUMNS);
            e_rdy  = e_save && !dispatch_needs_dest;
          end else if (dispatch_needs_dest) begin
            e_deq = !fl_empty;
            e_rdy = e_deq;
          end else begin
            e_rdy = 1;
          end
        end
      end
    end

    chk("dispatch_ready", dispatch_ready, e_rdy);
    chk("fl_dequeue_valid", fl_dequeue_valid, e_deq);
    chk("fl_save_valid", fl_save_valid, e_save);
    chk("fl_restore_valid", fl_restore_valid, e_rs);
    chk("restore_req_ready", restore_req_ready, e_rs);
    chk("fl_revert_valid", fl_revert_valid, e_rev);
    chk("revert_req_ready", revert_req_ready, e_rev);
    chk("fl_enqueue_valid", fl_enqueue_valid, e_enq);
    chk("restore_done", restore_done, m_done);
    chk("restore_done_success", restore_done_success, m_dsucc);
    chk("ctrl_error", ctrl_error, m_err);
    if (e_rdy && dispatch_needs_dest && fq.size() > 0) chk("dest_tag", dispatch_dest_tag, fq[0]);
    if (e_rdy && dispatch_needs_ckpt) chk("ckpt_column", dispatch_ckpt_column, m_pend ? m_col : fl_save_column);
    if (e_enq) chk("enqueue_tag", fl_enqueue_tag, commit_free_tag);
    if (e_rev) chk("revert_tag", fl_revert_tag, revert_req_tag);
    if (e_save) chk("save_rob", fl_save_ROB_index, dispatch_ROB_index);
    if (e_rs) begin
      chk("restore_failed", fl_restore_failed, restore_req_failed);
      chk("restore_column", fl_restore_column, restore_req_column);
    end

    if (!nRST) begin
      m_cnt = 0; m_pend = 0; m_rev_last = 0; m_settle = 0; m_err = 0; m_done = 0; m_dsucc = 0;
    end else begin
      if (commit_free_valid && fl_full) m_err = 1;
      if (fail_i) begin
        if (fl_restore_success) m_cnt = 0;
        else                    m_err = 1;
      end else begin
        d = (e_save ? 1 : 0) - ((inv_i && fl_restore_success) ? 1 : 0);
        if (m_cnt + d < 0 || m_cnt + d > CHECKPOINT_COLUMNS) m_err = 1;
        else m_cnt = m_cnt + d;
      end
      m_done  = e_rs;
      m_dsucc = e_rs && fl_restore_success;
      if (e_rev || fail_i) m_pend = 0;
      else if (m_pend && e_deq) m_pend = 0;
      else if (e_save && dispatch_needs_dest) begin
        m_pend = 1;
        m_col  = fl_save_column;
      end
      m_settle   = fail_i;
      m_rev_last = revert_req_valid;
    end

    s_rst      = !nRST;
    s_deq      = fl_dequeue_valid;
    s_enq      = fl_enqueue_valid;
    s_enq_tag  = int'(fl_enqueue_tag);
    s_rev      = fl_revert_valid;
    s_rev_tag  = int'(fl_revert_tag);
    s_save     = fl_save_valid;
    s_save_col = int'(fl_save_column);
    s_rs       = fl_restore_valid;
    s_rs_f     = fl_restore_failed;
    s_rs_col   = int'(fl_restore_column);
    s_rs_ok    = fl_restore_success;
  end

  // ---- stimulus helpers (start and end just after a rising edge) ----
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_dispatch(input bit d, input bit c, input int rob, input int maxc,
                             output int cyc, output int tag, output int col);
    dispatch_valid      = 1'b1;
    dispatch_needs_dest = d;
    dispatch_needs_ckpt = c;
    dispatch_ROB_index  = ROB_index_t'(rob);
    cyc = 0; tag = -1; col = -1;
    while (1) begin
      @(negedge CLK);
      if (dispatch_ready) begin
        tag = int'(dispatch_dest_tag);
        col = int'(dispatch_ckpt_column);
        break;
      end
      cyc++;
      if (cyc >= maxc) break;
      tick();
    end
    tick();
    dispatch_valid = 1'b0; dispatch_needs_dest = 1'b0; dispatch_needs_ckpt = 1'b0;
  endtask

  task automatic do_restore(input bit f, input int col, input int maxc,
                            output int cyc, output int succ);
    restore_req_valid  = 1'b1;
    restore_req_failed = f;
    restore_req_column = checkpoint_column_t'(col);
    cyc = 0; succ = -1;
    while (1) begin
      @(negedge CLK);
      if (restore_req_ready) break;
      cyc++;
      if (cyc >= maxc) break;
      tick();
    end
    tick();
    restore_req_valid = 1'b0; restore_req_failed = 1'b0;
    @(negedge CLK);
    chk("restore_done_pulse", restore_done, 1);
    succ = int'(restore_done_success);
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    int cyc, tag, col, succ, n;
    // reset: a held dispatch must see no strobes
    dispatch_valid = 1'b1; dispatch_needs_dest = 1'b1;
    tick(); tick();
    @(negedge CLK);
    chk("reset_ready", dispatch_ready, 0);
    chk("reset_dequeue", fl_dequeue_valid, 0);
    chk("reset_error", ctrl_error, 0);
    tick();
    dispatch_valid = 1'b0; dispatch_needs_dest = 1'b0;
    nRST = 1'b1;
    tick();

    // dest-only dispatches on consecutive cycles
    for (int k = 0; k < 3; k++) begin
      do_dispatch(1, 0, k, 4, cyc, tag, col);
      chk("dest_only_latency", cyc, 0);
      chk("dest_only_tag", tag, NUM_ARCH_REGS + k);
    end

    // branch with dest: save then dequeue
    dispatch_valid = 1'b1; dispatch_needs_dest = 1'b1; dispatch_needs_ckpt = 1'b1;
    dispatch_ROB_index = ROB_index_t'(5);
    @(negedge CLK);
    chk("split_c0_save", fl_save_valid, 1);
    chk("split_c0_ready", dispatch_ready, 0);
    chk("split_c0_rob", fl_save_ROB_index, 5);
    tick();
    @(negedge CLK);
    chk("split_c1_dequeue", fl_dequeue_valid, 1);
    chk("split_c1_ready", dispatch_ready, 1);
    chk("split_c1_column", dispatch_ckpt_column, 0);
    chk("split_c1_tag", dispatch_dest_tag, NUM_ARCH_REGS + 3);
    tick();
    dispatch_valid = 1'b0; dispatch_needs_dest = 1'b0; dispatch_needs_ckpt = 1'b0;

    // free column 0, fill all four checkpoints, fifth stalls until an invalidate
    do_restore(0, 0, 4, cyc, succ);
    chk("inval_latency", cyc, 0);
    chk("inval_success", succ, 1);
    for (int k = 0; k < 4; k++) begin
      do_dispatch(0, 1, 10 + k, 4, cyc, tag, col);
      chk("ckpt_latency", cyc, 0);
      chk("ckpt_column", col, k);
    end
    dispatch_valid = 1'b1; dispatch_needs_ckpt = 1'b1; dispatch_ROB_index = ROB_index_t'(14);
    for (int k = 0; k < 3; k++) begin
      @(negedge CLK);
      chk("ckpt_full_ready", dispatch_ready, 0);
      chk("ckpt_full_save", fl_save_valid, 0);
      tick();
    end
    restore_req_valid = 1'b1; restore_req_failed = 1'b0; restore_req_column = '0;
    @(negedge CLK);
    chk("ckpt_full_inval_issue", restore_req_ready, 1);
    chk("ckpt_full_inval_ready", dispatch_ready, 0);
    tick();
    restore_req_valid = 1'b0;
    @(negedge CLK);
    chk("ckpt_fifth_ready", dispatch_ready, 1);
    chk("ckpt_fifth_column", dispatch_ckpt_column, 0);
    tick();
    dispatch_valid = 1'b0; dispatch_needs_ckpt = 1'b0;

    // rollback walk with dispatch and invalidate pending
    dispatch_valid = 1'b1; dispatch_needs_dest = 1'b1;
    restore_req_valid = 1'b1; restore_req_failed = 1'b0; restore_req_column = checkpoint_column_t'(1);
    for (int k = 0; k < 3; k++) begin
      revert_req_valid = 1'b1;
      revert_req_tag   = phys_reg_tag_t'(35 - k);
      @(negedge CLK);
      chk("revert_valid", fl_revert_valid, 1);
      chk("revert_tag", fl_revert_tag, 35 - k);
      chk("revert_blocks_dispatch", dispatch_ready, 0);
      chk("revert_blocks_restore", restore_req_ready, 0);
      tick();
    end
    revert_req_valid = 1'b0;
    n = 0;
    while (1) begin
      @(negedge CLK);
      if (restore_req_ready || n >= 4) break;
      n++;
      tick();
    end
    chk("post_revert_bubble", n, 1);
    chk("post_revert_restore", restore_req_ready, 1);
    chk("post_revert_dispatch", dispatch_ready, 1);
    chk("post_revert_tag", dispatch_dest_tag, 33);
    tick();
    dispatch_valid = 1'b0; dispatch_needs_dest = 1'b0; restore_req_valid = 1'b0;

    // mispredict while the split dequeue is pending
    dispatch_valid = 1'b1; dispatch_needs_dest = 1'b1; dispatch_needs_ckpt = 1'b1;
    dispatch_ROB_index = ROB_index_t'(7);
    @(negedge CLK);
    chk("mis_save", fl_save_valid, 1);
    tick();
    restore_req_valid = 1'b1; restore_req_failed = 1'b1;
    restore_req_column = checkpoint_column_t'(1); restore_req_ROB_index = ROB_index_t'(7);
    @(negedge CLK);
    chk("mis_restore_issue", restore_req_ready, 1);
    chk("mis_restore_failed", fl_restore_failed, 1);
    chk("mis_dequeue_dropped", fl_dequeue_valid, 0);
    tick();
    restore_req_valid = 1'b0; restore_req_failed = 1'b0; dispatch_needs_ckpt = 1'b0;
    @(negedge CLK);
    chk("settle_ready", dispatch_ready, 0);
    chk("settle_done", restore_done, 1);
    chk("settle_success", restore_done_success, 1);
    tick();
    @(negedge CLK);
    chk("after_settle_ready", dispatch_ready, 1);
    chk("after_settle_tag", dispatch_dest_tag, 34);
    tick();
    dispatch_valid = 1'b0; dispatch_needs_dest = 1'b0;
    for (int k = 0; k < 4; k++) begin
      do_dispatch(0, 1, 20 + k, 4, cyc, tag, col);
      chk("ckpt_after_flush_latency", cyc, 0);
      chk("ckpt_after_flush_column", col, k);
    end

    // drain the free list, then refill one tag through commit
    n = 0;
    for (int i = 0; i < 40; i++) begin
      do_dispatch(1, 0, i, 2, cyc, tag, col);
      if (cyc != 0) break;
      n++;
    end
    chk("drain_count", n, 29);
    dispatch_valid = 1'b1; dispatch_needs_dest = 1'b1;
    commit_free_valid = 1'b1; commit_free_tag = phys_reg_tag_t'(40);
    @(negedge CLK);
    chk("empty_stall", dispatch_ready, 0);
    chk("commit_forward", fl_enqueue_valid, 1);
    tick();
    commit_free_valid = 1'b0;
    @(negedge CLK);
    chk("refill_ready", dispatch_ready, 1);
    chk("refill_tag", dispatch_dest_tag, 40);
    chk("no_error_yet", ctrl_error, 0);
    tick();
    dispatch_valid = 1'b0; dispatch_needs_dest = 1'b0;

    // commit into a full free list after a fresh reset
    nRST = 1'b0;
    tick(); tick();
    nRST = 1'b1;
    commit_free_valid = 1'b1; commit_free_tag = phys_reg_tag_t'(45);
    @(negedge CLK);
    chk("full_commit_forward", fl_enqueue_valid, 1);
    chk("full_error_before", ctrl_error, 0);
    tick();
    commit_free_valid = 1'b0;
    @(negedge CLK);
    chk("full_error_after", ctrl_error, 1);
    tick(); tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
